// File: rtl/func_scan_ctrl.sv
// Raster-scan sequencer for a fixed-latency pixel function unit: issues (x,y) under credit,
// re-tags each result with its coordinate and buffers it in a fall-through FIFO.
module func_scan_ctrl #(
    parameter int CORDW = 8,
    parameter int LAT   = 4,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [CORDW-1:0] x_start,
    input  logic signed [CORDW-1:0] y_start,
    input  logic signed [CORDW-1:0] x_end,
    input  logic signed [CORDW-1:0] y_end,
    output logic                    busy,
    output logic                    done,
    output logic signed [CORDW-1:0] fx,
    output logic signed [CORDW-1:0] fy,
    input  logic                    fr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [CORDW-1:0] out_x,
    output logic signed [CORDW-1:0] out_y,
    output logic                    out_r
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LAT + 1);

    state_t                  state_r, state_s;
    logic signed [CORDW-1:0] fx_r, fy_r, xs_r, xe_r, ye_r;
    logic                    done_r, done_s;
    logic                    issue_s, start_ok_s, empty_win_s, last_s, credit_s, drain_done_s;

    logic [LAT-1:0]          vld_r;
    logic [CORDW-1:0]        px_r [LAT];
    logic [CORDW-1:0]        py_r [LAT];
    logic [IW-1:0]           inflight_s;

    logic [CORDW-1:0]        mx_r [DEPTH];
    logic [CORDW-1:0]        my_r [DEPTH];
    logic [DEPTH-1:0]        mr_r;
    logic [AW-1:0]           rd_r, wr_r;
    logic [CW-1:0]           cnt_r;
    logic                    push_s, pop_s;

    assign empty_win_s = (x_end < x_start) || (y_end < y_start);
    assign last_s      = (fx_r == xe_r) && (fy_r == ye_r);
    assign push_s      = vld_r[LAT-1];
    assign pop_s       = (cnt_r != '0) && out_ready;
    // A same-cycle pop earns no credit: only registered occupancy is counted.
    assign credit_s    = (32'(inflight_s) + 32'(cnt_r)) < 32'(DEPTH);
    assign drain_done_s = (inflight_s == '0) &&
                          ((cnt_r == '0) || ((cnt_r == CW'(1)) && pop_s));

    // Count valid tags still travelling through the unit.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight_s = inflight_s + IW'(vld_r[i]);
        end
    end

    // Next-state and issue decision.
    always_comb begin
        state_s    = state_r;
        issue_s    = 1'b0;
        start_ok_s = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (empty_win_s) begin
                        done_s = 1'b1;
                    end else begin
                        start_ok_s = 1'b1;
                        state_s    = SCAN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (credit_s) begin
                    issue_s = 1'b1;
                    state_s = last_s ? DRAIN : SCAN;
                end else begin
                    state_s = SCAN;
                end
            end
            DRAIN: begin
                if (drain_done_s) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, window latch and raster coordinate stepping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
            fx_r    <= '0;
            fy_r    <= '0;
            xs_r    <= '0;
            xe_r    <= '0;
            ye_r    <= '0;
        end else begin
            state_r <= state_s;
            done_r  <= done_s;
            if (start_ok_s) begin
                xs_r <= x_start;
                xe_r <= x_end;
                ye_r <= y_end;
                fx_r <= x_start;
                fy_r <= y_start;
            end else if (issue_s && !last_s) begin
                // Equality-only wrap keeps the signed max edge overflow-free.
                if (fx_r == xe_r) begin
                    fx_r <= xs_r;
                    fy_r <= fy_r + CORDW'(1);
                end else begin
                    fx_r <= fx_r + CORDW'(1);
                end
            end
        end
    end

    // Tag pipe mirroring the unit latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int i = 0; i < LAT; i++) begin
                px_r[i] <= '0;
                py_r[i] <= '0;
            end
        end else begin
            vld_r[0] <= issue_s;
            px_r[0]  <= fx_r;
            py_r[0]  <= fy_r;
            for (int i = 1; i < LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
                px_r[i]  <= px_r[i-1];
                py_r[i]  <= py_r[i-1];
            end
        end
    end

    // Result FIFO, first-word fall-through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_r  <= '0;
            wr_r  <= '0;
            cnt_r <= '0;
            mr_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mx_r[i] <= '0;
                my_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mx_r[wr_r] <= px_r[LAT-1];
                my_r[wr_r] <= py_r[LAT-1];
                mr_r[wr_r] <= fr;
                wr_r       <= (wr_r == AW'(DEPTH - 1)) ? '0 : wr_r + AW'(1);
            end
            if (pop_s) begin
                rd_r <= (rd_r == AW'(DEPTH - 1)) ? '0 : rd_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign busy      = (state_r != IDLE);
    assign done      = done_r;
    assign fx        = fx_r;
    assign fy        = fy_r;
    assign out_valid = (cnt_r != '0);
    assign out_x     = mx_r[rd_r];
    assign out_y     = my_r[rd_r];
    assign out_r     = mr_r[rd_r];

    func_scan_ctrl_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .cnt   (cnt_r)
    );

endmodule

// Occupancy checker: credit issue must make FIFO overflow impossible.
module func_scan_ctrl_chk #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] cnt
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (32'(cnt) >= DEPTH)));
endmodule
